// File: rtl/md_sched_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and default busy-period lengths.
package md_defs;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

  // Codes 6 and 7 are reserved and have no effect.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_sched_unit.sv
// EX-stage multiply/divide resource: owns HI/LO, computes the result at the
// start edge and holds it back until the fixed busy period expires.
module md_sched_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output md_state_e   dbg_state
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_we_q, pend_we_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [63:0]        res;
  logic [63:0]        a_ext, b_ext;
  logic [31:0]        b_safe, a_mag, b_mag, q_mag, r_mag;
  logic               div_by_zero;

  assign div_by_zero = (b == 32'd0);
  // Substitute 1 for a zero divisor so the divider never produces X; the
  // result is discarded at commit anyway.
  assign b_safe = div_by_zero ? 32'd1 : b;

  always_comb begin
    a_ext = 64'd0;
    b_ext = 64'd0;
    a_mag = 32'd0;
    b_mag = 32'd0;
    q_mag = 32'd0;
    r_mag = 32'd0;
    res   = 64'd0;
    case (md_op)
      MD_MULT: begin
        a_ext = {{32{a[31]}}, a};
        b_ext = {{32{b[31]}}, b};
        res   = a_ext * b_ext;
      end
      MD_MULTU: begin
        a_ext = {32'd0, a};
        b_ext = {32'd0, b};
        res   = a_ext * b_ext;
      end
      MD_DIV: begin
        // Divide magnitudes, then restore signs: quotient negative when the
        // signs differ, remainder follows the dividend.
        a_mag = mag32(a);
        b_mag = mag32(b_safe);
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        res[31:0]  = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
        res[63:32] = a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      MD_DIVU: begin
        res[31:0]  = a / b_safe;
        res[63:32] = a % b_safe;
      end
      default: res = 64'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_d   = ST_MUL;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
              pend_hi_d = res[63:32];
              pend_lo_d = res[31:0];
              pend_we_d = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_DIV;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              pend_hi_d = res[63:32];
              pend_lo_d = res[31:0];
              pend_we_d = !div_by_zero;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        // start is ignored here; the hazard unit should never allow it.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_sched_unit.sv
// Scoreboard bench for md_sched_unit: expected {HI,LO} pushed at issue,
// popped when busy drops; busy length and HI/LO hold checked each cycle.
module tb_md_sched_unit;
  import md_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi_out, lo_out;
  md_state_e   dbg_state;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  md_sched_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: {HI,LO} after an operation, from the current HI/LO.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sp;
    int     sx, sy, q, r;
    model = {h, l};
    case (op)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        model = sp;
      end
      3'd1: model = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y != 32'd0) begin
          sx = x;
          sy = y;
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
          end else begin
            q = sx / sy;
            r = sx % sy;
          end
          model = {r, q};
        end
      end
      3'd3: if (y != 32'd0) model = {x % y, x / y};
      3'd4: model = {x, l};
      3'd5: model = {h, x};
      default: ;
    endcase
  endfunction

  // Issue a mult/div; inj>0 drives an illegal MULTU 3x3 during busy cycle inj.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int inj);
    int          n;
    logic [63:0] old;
    n = (op == 3'd0 || op == 3'd1) ? MULT_N : DIV_N;
    old = {hi_m, lo_m};
    exp_q.push_back(model(op, x, y, hi_m, lo_m));
    {hi_m, lo_m} = model(op, x, y, hi_m, lo_m);
    start = 1'b1; md_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      check_eq("busy_high", {63'd0, busy}, 64'd1);
      check_eq("hilo_hold", {hi_out, lo_out}, old);
      if (i == inj) begin
        start = 1'b1; md_op = MD_MULTU; a = 32'd3; b = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq("busy_low", {63'd0, busy}, 64'd0);
    if (exp_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
    else check_eq("result", {hi_out, lo_out}, exp_q.pop_front());
  endtask

  // Single-cycle ops (MTHI/MTLO/reserved): visible next cycle, never busy.
  task automatic run_mt(input logic [2:0] op, input logic [31:0] x);
    exp_q.push_back(model(op, x, 32'd0, hi_m, lo_m));
    {hi_m, lo_m} = model(op, x, 32'd0, hi_m, lo_m);
    start = 1'b1; md_op = op; a = x; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("mt_busy", {63'd0, busy}, 64'd0);
    if (exp_q.size() == 0) check_eq("sb_empty", 64'd1, 64'd0);
    else check_eq("mt_result", {hi_out, lo_out}, exp_q.pop_front());
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_hilo", {hi_out, lo_out}, 64'd0);
    check_eq("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 0);
    check_eq("mult_lit", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    check_eq("multu_lit", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    check_eq("div_lit", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU,  32'd7, 32'd2, 0);
    check_eq("divu_lit", {hi_out, lo_out}, 64'h0000_0001_0000_0003);

    run_mt(MD_MTHI, 32'h11);
    run_mt(MD_MTLO, 32'h22);
    run_op(MD_DIV, 32'd1234, 32'd0, 0);
    check_eq("div0_lit", {hi_out, lo_out}, 64'h0000_0011_0000_0022);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("divovf_lit", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    run_op(MD_DIV, 32'd100, 32'd7, 3);
    check_eq("inject_lit", {hi_out, lo_out}, 64'h0000_0002_0000_000E);

    run_mt(3'd6, 32'hDEAD_BEEF);
    run_mt(3'd7, 32'hCAFE_F00D);

    for (int k = 0; k < 6; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(rop, ra, rb, 0);
    end

    // Reset during cycle T+3 of a MULT: immediate clear, no late commit.
    start = 1'b1; md_op = MD_MULT; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("async_rst_hilo", {hi_out, lo_out}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("no_late_busy", {63'd0, busy}, 64'd0);
    check_eq("no_late_commit", {hi_out, lo_out}, 64'd0);
    run_mt(MD_MTLO, 32'd5);
    check_eq("mtlo_lit", {32'd0, lo_out}, 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched_unit.md
Name: md_sched_unit

Overview:
- Multi-cycle multiply/divide resource for the 5-stage MIPS pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed latency.
- Exports `busy` so the hazard unit can stall D-stage mult/div/mfhi/mflo/mthi/mtlo while the resource is occupied.
- Sits in the EX stage and takes operands after EX forwarding (MFRSE/MFRTE).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- start  in  1  EX-stage instruction is a mult/multu/div/divu/mthi/mtlo; sampled on the clk edge
- md_op  in  3  operation code (see package)
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- busy  out  1  operation in flight
- hi_out  out  32  HI register (used by mfhi)
- lo_out  out  32  LO register (used by mflo)

Behaviour:
- Reset values: busy=0, hi_out=0, lo_out=0, state=IDLE, counter=0, pending results=0. Reset asserted mid-operation aborts it; HI/LO stay 0; no late commit.
- States: IDLE, MUL, DIV.
  - IDLE→MUL: edge with start=1 and md_op in {MULT,MULTU}.
  - IDLE→DIV: edge with start=1 and md_op in {DIV,DIVU}.
  - MUL/DIV→IDLE: edge where counter==0.
- Start-edge actions:
  - Operands are latched and results computed into pending_hi/pending_lo.
  - counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES.
- Timing for start sampled at edge T:
  - busy=1 during cycles T+1 .. T+N.
  - HI/LO commit at the edge closing cycle T+N.
  - New HI/LO and busy=0 both become visible in cycle T+N+1.
- Counter decrements once per cycle while in MUL/DIV.
- busy is registered and equals (state!=IDLE). The hazard unit stalls on (busy | start) for D-stage MD instructions, so start while busy does not occur legally. If it does, start is ignored and the operation in flight is unaffected.
- MTHI/MTLO with start=1 in IDLE: HI (or LO) <= a at that edge; no busy cycles.
- Reserved md_op (6, 7) with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32→64; {HI,LO} = product.
  - MULTU: unsigned 32x32→64; {HI,LO} = product.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient; HI = remainder.
  - Divide by zero (b==0): full DIV_CYCLES busy period still runs; HI/LO unchanged at commit.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (no trap).
- hi_out/lo_out are direct register outputs; no bypass of pending results.

Decomposition:
- Package md_defs:
  - md_op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State encoding: IDLE=0, MUL=1, DIV=2.
  - Default cycle constants.
- Single module, no sub-module. The arithmetic is one combinational block feeding the pending registers. A later iterative divider would be split out as md_divider.

Test Plan:
- Reset then idle: assert reset=0 mid-run → busy=0, hi_out=0, lo_out=0 at once, no commit afterwards.
- MULT a=0xFFFFFFFF, b=2 at edge T → busy high T+1..T+5; at T+6 hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE, busy=0. Same with MULTU → hi_out=1, lo_out=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles; then lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU a=7, b=2 → lo_out=3, hi_out=1.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO (each takes effect next cycle, busy stays 0); DIV b=0 → busy 10 cycles; HI/LO still 0x11/0x22.
- start asserted during busy (MULTU 3×3 mid-DIV) → ignored: DIV result commits on schedule; HI/LO never show 9; busy falls exactly at T+11.
- Reset pulse at cycle T+3 of a MULT → busy=0 at once, HI/LO=0; after release, a fresh MTLO a=5 → lo_out=5 next cycle.
